jump_input_conditioner: RTL and testbench

- Upstream of the player block. Replaces the direct wiring of the raw jump button onto the player's jump_r input.
- Conditions the jump button in the fast clock domain:
  - synchronises and debounces the button;
  - detects presses;
  - buffers a press until the next simulation tick.
- Drives jump_r as a clean level aligned to sim ticks, so the player sees each jump for a bounded, tick-quantised duration (variable jump height).

---
 rtl/jump_input_conditioner.sv | 136 +++++++++++++
 tb/tb_jump_input_conditioner.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_input_conditioner.sv
// Conditions the raw jump button: synchronise, debounce, detect presses, and
// hold a buffered press until the next sim tick, then drive a tick-quantised jump_r.
module jump_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MIN_HOLD_TICKS  = 2,
    parameter int MAX_HOLD_TICKS  = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       sim_clk,
    output logic       jump_r,
    output logic       btn_db,
    output logic       press_pulse,
    output logic [7:0] press_count,
    output logic [1:0] state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] MIN_TICKS = 8'(MIN_HOLD_TICKS);
    localparam logic [7:0] MAX_TICKS = 8'(MAX_HOLD_TICKS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        ACTIVE  = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    logic          btn_s1_q, btn_s2_q;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic          btn_db_q, btn_db_d;
    logic          press_q, press_d;
    logic [7:0]    count_q, count_d;
    logic          sim_s1_q, sim_s2_q, sim_s3_q;
    logic          sim_rise;
    state_t        state_q;
    logic          jump_q;
    logic [7:0]    tick_q;

    // Input synchronisers; sim_clk is treated purely as data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            sim_s1_q <= 1'b0;
            sim_s2_q <= 1'b0;
            sim_s3_q <= 1'b0;
        end else begin
            btn_s1_q <= btn_raw;
            btn_s2_q <= btn_s1_q;
            sim_s1_q <= sim_clk;
            sim_s2_q <= sim_s1_q;
            sim_s3_q <= sim_s2_q;
        end
    end

    assign sim_rise = sim_s2_q & ~sim_s3_q;

    // The debounced level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        db_cnt_d = '0;
        btn_db_d = btn_db_q;
        press_d  = 1'b0;
        count_d  = count_q;
        if (btn_s2_q != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d = btn_s2_q;
                if (btn_s2_q) begin
                    press_d = 1'b1;
                    count_d = count_q + 8'd1;
                end
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt_q <= '0;
            btn_db_q <= 1'b0;
            press_q  <= 1'b0;
            count_q  <= 8'd0;
        end else begin
            db_cnt_q <= db_cnt_d;
            btn_db_q <= btn_db_d;
            press_q  <= press_d;
            count_q  <= count_d;
        end
    end

    // A press is buffered in ARMED; releasing there still yields a minimum-length jump.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            jump_q  <= 1'b0;
            tick_q  <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press_q) state_q <= ARMED;
                end
                ARMED: begin
                    if (sim_rise) begin
                        state_q <= ACTIVE;
                        jump_q  <= 1'b1;
                        tick_q  <= 8'd1;
                    end
                end
                ACTIVE: begin
                    if (sim_rise) begin
                        if ((tick_q == MAX_TICKS) || ((tick_q >= MIN_TICKS) && !btn_db_q)) begin
                            jump_q  <= 1'b0;
                            state_q <= btn_db_q ? LOCKOUT : IDLE;
                        end else begin
                            tick_q <= tick_q + 8'd1;
                        end
                    end
                end
                LOCKOUT: begin
                    if (!btn_db_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign jump_r      = jump_q;
    assign btn_db      = btn_db_q;
    assign press_pulse = press_q;
    assign press_count = count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_jump_input_conditioner.sv
// Bench for jump_input_conditioner: directed scenarios plus random button activity,
// every cycle compared against a rule-level model of debounce, tick alignment and jump hold.
module tb_jump_input_conditioner;

    localparam int DB     = 4;
    localparam int MIN_T  = 2;
    localparam int MAX_T  = 6;
    localparam int SIM_P  = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_raw = 1'b0;
    logic       sim_clk = 1'b0;
    logic       jump_r;
    logic       btn_db;
    logic       press_pulse;
    logic [7:0] press_count;
    logic [1:0] state;

    jump_input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .MIN_HOLD_TICKS(MIN_T),
        .MAX_HOLD_TICKS(MAX_T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .sim_clk(sim_clk),
        .jump_r(jump_r),
        .btn_db(btn_db),
        .press_pulse(press_pulse),
        .press_count(press_count),
        .state(state)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: samples held as queues (newest first), hold tracked in whole ticks.
    int m_db, m_pp, m_cnt, m_mode, m_jump, m_ticks;
    int bs_q[$];
    int ss_q[$];
    int run_q[$];
    int coinc_seen = 0;
    int coinc_edge = 0;

    task automatic model_reset();
        m_db = 0; m_pp = 0; m_cnt = 0; m_mode = 0; m_jump = 0; m_ticks = 0;
        bs_q = '{0, 0};
        ss_q = '{0, 0, 0};
        run_q.delete();
    endtask

    task automatic model_step(input int b_in, input int s_in);
        int btn_s, rise, old_db, old_pp, flip, new_db, new_pp;
        btn_s  = bs_q[1];
        rise   = (ss_q[1] == 1 && ss_q[2] == 0) ? 1 : 0;
        old_db = m_db;
        old_pp = m_pp;
        flip   = 0;
        if (btn_s == m_db) run_q.delete();
        else begin
            run_q.push_back(btn_s);
            if (run_q.size() == DB) begin
                flip = 1;
                run_q.delete();
            end
        end
        new_db = flip ? 1 - m_db : m_db;
        new_pp = (flip == 1 && new_db == 1) ? 1 : 0;
        if (new_pp == 1) m_cnt = (m_cnt + 1) % 256;
        case (m_mode)
            0: begin
                if (old_pp == 1) begin
                    m_mode = 1;
                    if (rise == 1) begin
                        coinc_seen++;
                        coinc_edge = cyc;
                    end
                end
            end
            1: if (rise == 1) begin m_mode = 2; m_jump = 1; m_ticks = 1; end
            2: if (rise == 1) begin
                if (m_ticks == MAX_T || (m_ticks >= MIN_T && old_db == 0)) begin
                    m_jump = 0;
                    m_mode = (old_db == 1) ? 3 : 0;
                end else m_ticks++;
            end
            default: if (old_db == 0) m_mode = 0;
        endcase
        m_db = new_db;
        m_pp = new_pp;
        bs_q.push_front(b_in); void'(bs_q.pop_back());
        ss_q.push_front(s_in); void'(ss_q.pop_back());
    endtask

    // jump_r pulse monitor (DUT observation, compared only against fixed expectations).
    int rises = 0;
    int hl = 0;
    int last_len = 0;
    int rise_edge = 0;
    logic jr_prev = 1'b0;

    // sim_clk is launched just after a clk edge, as from the divider flop; counting
    // that launch edge, jump_r moves on the fourth clk edge.
    task automatic tick(input logic b);
        @(posedge clk);
        if (reset) model_reset();
        else model_step(int'(btn_raw), int'(sim_clk));
        #1;
        chk("jump_r", int'(jump_r), m_jump);
        chk("btn_db", int'(btn_db), m_db);
        chk("press_pulse", int'(press_pulse), m_pp);
        chk("press_count", int'(press_count), m_cnt);
        chk("state", int'(state), m_mode);
        if (jump_r && !jr_prev) begin
            rises++;
            hl = 0;
            rise_edge = cyc;
        end
        if (jump_r) hl++;
        if (!jump_r && jr_prev) last_len = hl;
        jr_prev = jump_r;
        btn_raw = b;
        sim_clk = ((cyc % SIM_P) < (SIM_P / 2)) ? 1'b1 : 1'b0;
        cyc++;
    endtask

    task automatic run(input int n, input logic b);
        repeat (n) tick(b);
    endtask

    task automatic align(input int phase);
        int guard = 0;
        while ((cyc % SIM_P) != phase && guard < SIM_P) begin
            tick(1'b0);
            guard++;
        end
    endtask

    task automatic wait_rise(input string tag, input int budget, input logic b);
        int r0 = rises;
        for (int i = 0; i < budget; i++) begin
            tick(b);
            if (rises != r0) break;
        end
        chk(tag, rises - r0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, c0, lvl, len;
        model_reset();
        run(4, 1'b0);
        chk("rst_jump", int'(jump_r), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_count", int'(press_count), 0);
        reset = 1'b0;
        run(20, 1'b0);

        // Glitch shorter than the debounce window.
        r0 = rises;
        run(3, 1'b1);
        run(20, 1'b0);
        chk("glitch_count", int'(press_count), 0);
        chk("glitch_state", int'(state), 0);
        chk("glitch_jumps", rises - r0, 0);

        // Clean tap: honoured for the minimum hold.
        align(0);
        run(10, 1'b1);
        chk("tap_count", int'(press_count), 1);
        chk("tap_armed", int'(state), 1);
        run(30, 1'b0);
        wait_rise("tap_rise_timeout", 20, 1'b0);
        run(100, 1'b0);
        chk("tap_len", last_len, MIN_T * SIM_P);
        chk("tap_idle", int'(state), 0);

        // Long hold: capped at the maximum, then locked out until release.
        align(10);
        r0 = rises;
        run(20 * SIM_P, 1'b1);
        chk("hold_len", last_len, MAX_T * SIM_P);
        chk("hold_lockout", int'(state), 3);
        chk("hold_jump_low", int'(jump_r), 0);
        chk("hold_one_jump", rises - r0, 1);
        run(60, 1'b0);
        chk("hold_idle", int'(state), 0);
        chk("hold_no_retrigger", rises - r0, 1);

        // Variable height: release after three full periods high.
        align(10);
        wait_rise("var_rise_timeout", 100, 1'b1);
        run(3 * SIM_P + 5, 1'b1);
        run(100, 1'b0);
        chk("var_len", last_len, 4 * SIM_P);
        chk("var_idle", int'(state), 0);

        // Press pulse landing on the same cycle as a sim tick in IDLE.
        c0 = coinc_seen;
        align(SIM_P - 4);
        run(10, 1'b1);
        run(60, 1'b0);
        chk("coinc_hit", coinc_seen - c0, 1);
        chk("coinc_next_tick", rise_edge - coinc_edge, SIM_P);
        run(120, 1'b0);
        chk("coinc_len", last_len, MIN_T * SIM_P);

        // Random bouncing followed by random holds and gaps.
        lvl = 0;
        for (int i = 0; i < 60; i++) begin
            lvl = 1 - lvl;
            run($urandom_range(1, 8), lvl[0]);
        end
        run(100, 1'b0);
        for (int i = 0; i < 8; i++) begin
            len = $urandom_range(5, 300);
            run(len, 1'b1);
            for (int k = 0; k < 3; k++) begin
                run($urandom_range(1, 3), 1'b0);
                run($urandom_range(1, 3), 1'b1);
            end
            run($urandom_range(20, 200), 1'b0);
        end
        run(100, 1'b0);
        chk("rand_idle", int'(state), 0);

        // Counter wrap after 256 presses from reset.
        reset = 1'b1;
        run(3, 1'b0);
        reset = 1'b0;
        chk("wrap_start", int'(press_count), 0);
        for (int i = 0; i < 256; i++) begin
            run(6, 1'b1);
            run(6, 1'b0);
            if (i == 254) chk("wrap_255", int'(press_count), 255);
        end
        chk("wrap_zero", int'(press_count), 0);
        run(400, 1'b0);

        // Asynchronous reset in the middle of a jump (tick count 3).
        align(10);
        wait_rise("arst_rise_timeout", 100, 1'b1);
        run(2 * SIM_P + 10, 1'b1);
        chk("arst_pre_jump", int'(jump_r), 1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("arst_jump", int'(jump_r), 0);
        chk("arst_state", int'(state), 0);
        chk("arst_db", int'(btn_db), 0);
        chk("arst_count", int'(press_count), 0);
        btn_raw = 1'b0;
        run(3, 1'b0);
        reset = 1'b0;
        r0 = rises;
        run(200, 1'b0);
        chk("arst_no_jump", rises - r0, 0);
        chk("arst_idle", int'(state), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
